// File: rtl/serial_sub_if.sv
// Handshake/bus bundle for the bit-serial subtractor.
// The controller side uses the master modport and the subtractor uses the slave modport.
// dbg_state mirrors the FSM state so that checkers can bind to it.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
//
// Handshake: start is looked at only while the block is not busy (IDLE or DONE).
// A start seen there is accepted at that clock edge, and a, b and bin are captured.
// busy is high for the N RUN cycles that follow.
// done pulses high for one cycle, and from that cycle d/bout (and ovf) are valid.
// They stay valid until the next accepted start.
// A start raised while busy=1 is dropped; nothing is queued.
interface serial_sub_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif
    logic [1:0]   dbg_state;

    modport master (
        output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  busy, done, d, bout, dbg_state
    );

    modport slave (
        input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output busy, done, d, bout, dbg_state
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: d = a - b - bin, LSB first, one bit per clock.
// It uses one full-subtractor cell and a registered borrow.
// The FSM runs IDLE -> RUN (N cycles) -> DONE (1 cycle).
// If start is high in DONE, the block goes straight back to RUN.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  d_sr;
    logic          br_q;
    logic          bout_q;
    logic          accept;
    logic          last;
    logic          a_i;
    logic          b_i;
    logic          diff_i;
    logic          br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic          a_msb_q;
    logic          b_msb_q;
    logic          ovf_q;
`endif

    // The single full-subtractor cell works on the current LSBs and the running borrow.
    assign a_i     = a_sr[0];
    assign b_i     = b_sr[0];
    assign diff_i  = a_i ^ b_i ^ br_q;
    assign br_next = (~a_i & b_i) | (~a_i & br_q) | (b_i & br_q);

    // Next-state logic: accept start only in IDLE/DONE, and leave RUN after bit N-1.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_BIT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: capture operands on accept, then shift one bit per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            br_q   <= 1'b0;
            bout_q <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br_q  <= bus.bin;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            // Each new difference bit enters at the MSB, so bit 0 ends up at the LSB after N shifts.
            d_sr  <= (d_sr >> 1) | (N'(diff_i) << (N - 1));
            br_q  <= br_next;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                bout_q <= br_next;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow: the operand signs differ and the result sign differs from the minuend sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_msb_q <= bus.a[N-1];
            b_msb_q <= bus.b[N-1];
        end else if (state_q == RUN && last) begin
            // On the final RUN edge, diff_i is the result MSB.
            ovf_q <= (a_msb_q != b_msb_q) && (diff_i != a_msb_q);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.d         = d_sr;
    assign bus.bout      = bout_q;
    assign bus.dbg_state = state_q;
endmodule
